// File: rtl/z_csa_stream_accum_pkg.sv
// rtl/z_csa_stream_accum_pkg.sv - shared defaults and FSM state encodings for the CSA stream accumulator
//
// Purpose: default adder geometry and counter width, plus the 2-bit FSM state
//          constants shared by the accumulator top level.
// Ports:   none (package).

package z_csa_stream_accum_pkg;

    localparam int K_DEF     = 8;
    localparam int M_DEF     = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/z_n_csa.sv
// rtl/z_n_csa.sv - N-bit carry-select adder built from M blocks of K bits
//
// Purpose: combinational unsigned adder, sum = a + b + c_in, split into M
//          carry-select blocks of K bits each.
// Ports:
//   a, b   in   N  addends
//   c_in   in   1  carry into block 0
//   sum    out  N  a + b + c_in mod 2^N
//   c_out  out  1  carry out of the top block

module z_n_csa #(
    parameter int K = 8,
    parameter int M = 4
) (
    input  logic [K*M-1:0] a,
    input  logic [K*M-1:0] b,
    input  logic           c_in,
    output logic [K*M-1:0] sum,
    output logic           c_out
);

    logic [M:0] carry;

    assign carry[0] = c_in;

    // Each block precomputes both carry-in cases; the incoming carry only
    // drives a mux, so the block-to-block chain is one select per block.
    for (genvar g = 0; g < M; g++) begin : g_blk
        logic [K:0] s0;
        logic [K:0] s1;

        assign s0 = {1'b0, a[g*K +: K]} + {1'b0, b[g*K +: K]};
        assign s1 = {1'b0, a[g*K +: K]} + {1'b0, b[g*K +: K]} + {{K{1'b0}}, 1'b1};

        assign sum[g*K +: K] = carry[g] ? s1[K-1:0] : s0[K-1:0];
        assign carry[g+1]    = carry[g] ? s1[K]     : s0[K];
    end

    assign c_out = carry[M];

endmodule

// File: rtl/z_csa_stream_accum.sv
// rtl/z_csa_stream_accum.sv - burst stream accumulator using the z_n_csa adder
//
// Purpose: sums a burst of len N-bit operands (one per handshake) and
//          presents a registered sum plus sticky carry-out flag.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, len           burst request and operand count (sampled in IDLE)
//   in_valid/in_ready    operand handshake, in_data operand
//   out_valid/out_ready  result handshake
//   out_sum, out_ovf     accumulated sum mod 2^N, sticky carry-out
//   busy                 FSM not in IDLE

module z_csa_stream_accum
    import z_csa_stream_accum_pkg::*;
#(
    parameter int K     = K_DEF,
    parameter int M     = M_DEF,
    parameter int N     = K * M,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic             busy
);

    logic [1:0]       state;
    logic [N-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] remaining;

    logic [N-1:0]     csa_sum;
    logic             csa_cout;
    logic             beat;

    z_n_csa #(
        .K (K),
        .M (M)
    ) u_csa (
        .a     (acc),
        .b     (in_data),
        .c_in  (1'b0),
        .sum   (csa_sum),
        .c_out (csa_cout)
    );

    assign in_ready  = (state == ST_ACCUM);
    assign beat      = in_ready && in_valid;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // acc and ovf are registers, so the result is stable for all of DONE.
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        ovf       <= 1'b0;
                        remaining <= len;
                        state     <= (len == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        acc       <= csa_sum;
                        ovf       <= ovf | csa_cout;
                        remaining <= remaining - 1'b1;
                        // Leaving at 1 keeps the counter from ever wrapping.
                        if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
